booth_datapath: RTL
===================

# booth_datapath

Radix-2 Booth multiplier datapath: the arithmetic stage driven by the Booth control FSM. It consumes the FSM's `load` (FSM `rst_out`) and `enP` strobes, latches signed operands, and performs one add/subtract-and-shift step per enabled cycle. It returns the step `counter` the FSM uses to terminate, and presents the signed product.

## Interface
- `WIDTH`, 4: operand width in bits, two's complement.
- `COUNTER_SIZE`, 3: step counter width. Must satisfy WIDTH < 2**COUNTER_SIZE.
- `clk`  input  1  rising-edge clock.
- `rst_in`  input  1  reset. Asynchronous and active-high; clears every register.
- `load`  input  1  synchronous operand load and clear. Driven by the FSM `rst_out`.
- `enP`  input  1  step enable. Driven by the FSM `enP`.
- `mcand`  input  WIDTH  signed multiplicand, sampled only on load.
- `mplier`  input  WIDTH  signed multiplier, sampled only on load.
- `counter`  output  COUNTER_SIZE  number of Booth steps completed since the last load.
- `product`  output  2*WIDTH  signed product. Valid when `done`=1.
- `done`  output  1  high when `counter` == WIDTH.

## Operation
- Registers:
  - M: WIDTH bits, the latched multiplicand.
  - A: WIDTH+1 bits, the accumulator. The extra bit absorbs the M = −2^(WIDTH−1) case.
  - Q: WIDTH bits, multiplier/low product.
  - q1: 1 bit, Booth history bit.
  - cnt: COUNTER_SIZE bits.
- Priority per rising edge: `rst_in` > `load` > step > hold.
- Load:
  - M ← mcand.
  - A ← 0.
  - Q ← mplier.
  - q1 ← 0.
  - cnt ← 0.
- Step: taken when `enP`=1, `load`=0 and cnt < WIDTH.
  - Op select on {Q[0], q1}:
    - 01 → A ← A + sext(M).
    - 10 → A ← A − sext(M).
    - 00 or 11 → no change.
  - Then arithmetic right shift of {A,Q,q1} by one, with the A MSB replicated.
  - cnt ← cnt + 1.
  - All arithmetic is modulo 2^(WIDTH+1) on A.
- Guard: with `enP`=1 and cnt == WIDTH, no step is taken and all registers hold. The counter never exceeds WIDTH.
- Hold: with `enP`=0 and `load`=0, all registers keep their values.
- `product` = {A[WIDTH−1:0], Q}, combinational from the registers.
- `counter` = cnt.
- `done` = (cnt == WIDTH), combinational.
- Simultaneous `load` and `enP`: load wins and no step is taken. The FSM start state asserts both.
- `load` mid-operation or after done: restart from the new operands. The previous result is lost.
- `rst_in` mid-operation: all registers go to 0 immediately, regardless of `clk`.

## Timing
- Reset values:
  - `counter` = 0.
  - `product` = 0.
  - `done` = 0.
  - M, A, Q and q1 = 0.
- Edge L samples `load`=1 and loads the operands; `counter` = 0 after edge L.
- Edges L+1 … L+WIDTH, with `enP`=1, perform steps 1…WIDTH. `counter` reads k after step k.
- `done` and a valid `product` appear after edge L+WIDTH (WIDTH cycles of latency with continuous `enP`).
- `counter` reaches WIDTH in the same cycle that `done` goes high. The FSM sees it combinationally and drops `enP` for the following edge; the guard makes any extra enabled edge harmless.
- No output is registered separately. Outputs change only on clock edges or on `rst_in`.

## Structure
- Shared package `booth_pkg`:
  - default WIDTH and COUNTER_SIZE constants;
  - the control FSM state encoding (start=0, charge=1, final=2);
  - the Booth op enum (NOP, ADD, SUB).
- Sub-module `booth_step`: purely combinational. Takes A, Q, q1 and M; returns the next A, Q and q1 (op decode, add/sub, arithmetic shift).
- The top holds the registers, counter, guard and priority logic.

## Test plan
- 3 × 2: load, then 4 cycles of `enP` → `counter` steps 0,1,2,3,4; `done`=1; `product`=8'h06.
- −3 × 2 (4'hD, 4'h2) → `product`=8'hFA. Then 7 × −8 (4'h7, 4'h8) → `product`=8'hC8.
- −8 × −8 (4'h8, 4'h8) → `product`=8'h40. This exercises the extra accumulator bit.
- `enP` held high for 3 extra cycles after `done` → `counter` stays 4 and `product` is unchanged. `enP` dropped for 2 cycles mid-run → registers hold, and the final result is still correct.
- `load` and `enP` high together with new operands 5 × 5 after `counter`=2 → `counter`=0 on that edge; after 4 steps `product`=8'h19.
- `rst_in` pulsed between clock edges with `counter`=3 → `counter`, `product` and `done` go to 0 immediately. A subsequent load of 2 × 3 runs normally and gives `product`=8'h06.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared constants and encodings for the radix-2 Booth multiplier (datapath and control FSM).
package booth_pkg;
    localparam int DEF_WIDTH        = 4;
    localparam int DEF_COUNTER_SIZE = 3;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_CHARGE = 2'd1,
        ST_FINAL  = 2'd2
    } booth_state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Booth recoding of the {Q[0], q1} pair.
    function automatic booth_op_t booth_decode(input logic i_q0, input logic i_q1);
        case ({i_q0, i_q1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction
endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: op decode, add/sub of sign-extended M, arithmetic right shift.
import booth_pkg::*;

module booth_step #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);
    logic [WIDTH:0] w_msext;
    logic [WIDTH:0] w_sum;
    booth_op_t      w_op;

    assign w_msext = {i_m[WIDTH-1], i_m};
    assign w_op    = booth_decode(i_q[0], i_q1);

    always_comb begin
        w_sum = i_a;
        case (w_op)
            OP_ADD:  w_sum = i_a + w_msext;
            OP_SUB:  w_sum = i_a - w_msext;
            default: w_sum = i_a;
        endcase
    end

    // {A,Q,q1} shifted right by one with the accumulator sign replicated.
    assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q1 = i_q[0];
endmodule

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: operand latches, accumulator, step counter with end guard.
import booth_pkg::*;

module booth_datapath #(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int COUNTER_SIZE = DEF_COUNTER_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    load,
    input  logic                    enP,
    input  logic [WIDTH-1:0]        mcand,
    input  logic [WIDTH-1:0]        mplier,
    output logic [COUNTER_SIZE-1:0] counter,
    output logic [2*WIDTH-1:0]      product,
    output logic                    done
);
    logic [WIDTH-1:0]        r_m;
    logic [WIDTH:0]          r_a;
    logic [WIDTH-1:0]        r_q;
    logic                    r_q1;
    logic [COUNTER_SIZE-1:0] r_cnt;

    logic [WIDTH:0]          w_a_nxt;
    logic [WIDTH-1:0]        w_q_nxt;
    logic                    w_q1_nxt;
    logic                    w_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_a  (r_a),
        .i_q  (r_q),
        .i_q1 (r_q1),
        .i_m  (r_m),
        .o_a  (w_a_nxt),
        .o_q  (w_q_nxt),
        .o_q1 (w_q1_nxt)
    );

    // Guard keeps extra enabled edges after completion harmless.
    assign w_step = enP && (r_cnt < COUNTER_SIZE'(WIDTH));

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_m   <= '0;
            r_a   <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (load) begin
            r_m   <= mcand;
            r_a   <= '0;
            r_q   <= mplier;
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_q1  <= w_q1_nxt;
            r_cnt <= r_cnt + COUNTER_SIZE'(1);
        end
    end

    assign counter = r_cnt;
    assign product = {r_a[WIDTH-1:0], r_q};
    assign done    = (r_cnt == COUNTER_SIZE'(WIDTH));
endmodule
